uart_float_tx: RTL and testbench
================================

# uart_float_tx

UART transmit-side companion to the floating-point UART receive interface. It accepts a 32-bit IEEE-754 word (for example an FPU result) over a valid/ready handshake and serialises it onto the `tx` line as 8N1 frames, most significant byte first. A build-time option sends the word as eight uppercase ASCII hex characters plus `\n` instead of four raw bytes. It sits between the arithmetic datapath and the board UART pin.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate; `BIT_CYCLES = CLK_FREQ / BAUD` (integer division; 10416 at defaults).
- `HEX_ASCII`, 0: selects the transmit format.
  - 0: 4 raw bytes.
  - 1: 8 hex characters then 0x0A (9 bytes).

Ports:
- `clk_100MHz`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `result`  in  32  word to transmit; sampled only on acceptance.
- `result_valid`  in  1  `result` is presented.
- `result_ready`  out  1  block can accept a word.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  a frame sequence is in progress.
- `done_tick`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Acceptance happens when `result_valid && result_ready` at a rising edge.
  - `result` is latched into a 32-bit holding register.
  - The byte index resets to 0.
- Byte order is big-endian.
  - Raw mode: byte i = `hold[31-8i -: 8]`, i = 0..3.
  - Hex mode: char i = nibble `hold[31-4i -: 4]`, i = 0..7. Nibbles 0–9 map to 0x30+n; A–F map to 0x41+(n-10). Char 8 = 0x0A.
- Each byte is sent as: start bit (0), data bits LSB first, stop bit (1). Every bit lasts exactly `BIT_CYCLES` clocks.
- Sequencer states: IDLE, LOAD, SEND, NEXT.
  - IDLE -> LOAD on accept.
  - LOAD: presents byte[idx] to the bit engine and pulses its start; -> SEND.
  - SEND: waits for the bit engine's stop-bit-complete pulse; -> NEXT.
  - NEXT: if idx = NBYTES-1, assert `done_tick` and go to IDLE. Otherwise increment idx and go to LOAD.
  - NBYTES = 4 when `HEX_ASCII`=0, 9 when `HEX_ASCII`=1.
- LOAD and NEXT are zero-width on the line. The start bit of byte i+1 begins on the clock immediately after the stop bit of byte i ends, so there is no idle gap between bytes.
- `result_ready` = (state == IDLE). `busy` = !`result_ready`.
- While busy, `result_valid` and `result` are ignored. The holding register is not disturbed.
- Reset values: `tx`=1, `result_ready`=1, `busy`=0, `done_tick`=0, state IDLE, idx 0, all counters 0.
- Reset asserted mid-frame: `tx` goes to 1 immediately and asynchronously, and the in-flight word is discarded. The first word accepted after release is transmitted from its first byte with full-length bits.

## Timing
- Acceptance at edge k: `tx` falls at edge k+1 (start bit of byte 0). Latency is 1 clock.
- Line time per byte = 10·`BIT_CYCLES` clocks.
- Total sequence length from the first start-bit edge:
  - 4·10·`BIT_CYCLES` clocks in raw mode (416 640 at defaults).
  - 9·10·`BIT_CYCLES` clocks in hex mode (937 440 at defaults).
- `done_tick` is high for exactly one cycle, coinciding with the final cycle of the last stop bit.
- The next cycle is IDLE with `result_ready`=1. A new word accepted on that edge drives the next start bit one clock later.
- `result_valid` may stay high continuously. Exactly one word is consumed per sequence.

## Structure
- Shared package `uart_pkg` holds:
  - `uart_bit_cycles(clk, baud)` helper.
  - `ASCII_LF`, `ASCII_0`, `ASCII_A` constants.
  - the sequencer state enum.
  - a `hex_nibble_to_ascii` function.
- Sub-module `uart_tx_byte` is the bit engine.
  - Inputs: start pulse and an 8-bit byte.
  - Outputs: `tx`, `busy`, and a one-cycle `stop_done` pulse.
  - Contains a baud counter of width `$clog2(BIT_CYCLES)` and a 4-bit bit counter covering 0..9.
- Top level holds the sequencer, holding register and format mux.

## Test plan
- Reset: hold `reset_n`=0 for 10 cycles -> `tx`=1, `result_ready`=1, `busy`=0, `done_tick`=0. Assert reset during a frame -> `tx` returns to 1 within the same cycle.
- Raw mode, send 32'h3FC00000:
  - Line decodes to bytes 3F, C0, 00, 00.
  - Each bit is 10416 clocks.
  - `done_tick` fires 416 640 clocks after the first falling edge.
- Hex mode, send 32'hC0080000 -> line decodes to 43 30 30 38 30 30 30 30 0A.
- Back-to-back: hold `result_valid`=1, present 32'h3FC00000 then 32'hC0080000.
  - Second word is accepted on the cycle after `done_tick`.
  - Changing `result` mid-sequence does not alter transmitted bytes.
  - The two frames are contiguous.
- Reset mid-frame: assert `reset_n`=0 during byte 2 of 32'h12345678, release, then send 32'hDEADBEEF -> line decodes exactly DE AD BE EF.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART float transmitter:
//   - uart_bit_cycles()     : clocks per serial bit for a given clock and baud
//   - ASCII_LF/ASCII_0/ASCII_A : characters used by the hex text format
//   - seq_state_t           : word sequencer states
//   - hex_nibble_to_ascii() : 4-bit value to uppercase ASCII hex digit
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_SEND,
      SEQ_NEXT
   } seq_state_t;

   // Integer division, so the real baud rate is slightly above nominal
   function automatic int uart_bit_cycles(input int clk, input int baud);
      return clk / baud;
   endfunction

   function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] ch;
      if (nib < 4'd10) begin
         ch = ASCII_0 + {4'd0, nib};
      end else begin
         ch = ASCII_A + {4'd0, nib} - 8'd10;
      end
      return ch;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Bit engine: serialises one byte as an 8N1 frame (start 0, data LSB first,
// stop 1), each bit lasting BIT_CYCLES clocks.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle request to send 'data'
//   data        : byte to send, captured when start is taken
//   tx          : serial line, idles high
//   busy        : a frame is on the line
//   stop_done   : one-cycle pulse inside the stop bit, timed so a sequencer
//                 that hops through two bookkeeping states and then raises
//                 start lands the next start bit on the clock right after
//                 the stop bit ends (needs BIT_CYCLES >= 3)
// ---------------------------------------------------------------------------
module uart_tx_byte #(
   parameter int BIT_CYCLES = 10416
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       stop_done
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] EARLY_CNT = CW'(BIT_CYCLES - 3);

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          active;
   logic          frame_end;

   // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
   assign frame_end = active && (bit_cnt == 4'd9) && (baud_cnt == LAST_CNT);

   // Early completion pulse: three clocks before the stop bit ends the
   // sequencer sees it, walks SEND->NEXT->LOAD, and its start request
   // coincides with the final stop-bit clock.
   assign stop_done = active && (bit_cnt == 4'd9) && (baud_cnt == EARLY_CNT);
   assign busy      = active;

   // Frame engine: a start request is honoured when idle or on the very
   // last clock of the stop bit, which gives gap-free back-to-back bytes.
   // tx is a register so the line never glitches between bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx       <= 1'b1;
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (start && (!active || frame_end)) begin
         shreg    <= data;
         tx       <= 1'b0;
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (active) begin
         if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active  <= 1'b0;
               tx      <= 1'b1;
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               tx      <= (bit_cnt == 4'd8) ? 1'b1 : shreg[bit_cnt[2:0]];
            end
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_float_tx.sv
// ---------------------------------------------------------------------------
// uart_float_tx
// Accepts a 32-bit word over valid/ready and sends it most significant byte
// first as 8N1 frames, either as 4 raw bytes (HEX_ASCII=0) or as 8 uppercase
// hex characters followed by a line feed (HEX_ASCII=1).
// Ports:
//   clk_100MHz    : clock
//   reset_n       : asynchronous active-low reset
//   result        : word to send, captured on acceptance
//   result_valid  : result is presented
//   result_ready  : high while idle; acceptance = valid && ready at an edge
//   tx            : serial line, idles high
//   busy          : a word is being sent (inverse of result_ready)
//   done_tick     : one-cycle pulse on the last clock of the final stop bit
// ---------------------------------------------------------------------------
module uart_float_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int HEX_ASCII = 0
) (
   input  logic        clk_100MHz,
   input  logic        reset_n,
   input  logic [31:0] result,
   input  logic        result_valid,
   output logic        result_ready,
   output logic        tx,
   output logic        busy,
   output logic        done_tick
);

   localparam int BIT_CYCLES = uart_bit_cycles(CLK_FREQ, BAUD);
   localparam int NBYTES     = (HEX_ASCII != 0) ? 9 : 4;
   localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

   seq_state_t  state;
   logic [31:0] hold;
   logic [3:0]  idx;
   logic [7:0]  cur_byte;
   logic [3:0]  cur_nibble;
   logic        start;
   logic        stop_done;
   logic        unused_engine_busy;

   // Format mux: pick byte idx of the held word. Index 0 is the most
   // significant byte/nibble, so the bit offset is the inverted index.
   always_comb begin
      cur_byte   = 8'h00;
      cur_nibble = hold[{~idx[2:0], 2'b00} +: 4];
      if (HEX_ASCII != 0) begin
         if (idx == 4'd8) begin
            cur_byte = ASCII_LF;
         end else begin
            cur_byte = hex_nibble_to_ascii(cur_nibble);
         end
      end else begin
         cur_byte = hold[{~idx[1:0], 3'b000} +: 8];
      end
   end

   // The engine registers the byte on the edge that ends LOAD, so decoding
   // start from the state keeps acceptance-to-start-bit latency at one clock.
   assign start = (state == SEQ_LOAD);
   assign busy  = !result_ready;

   // Word sequencer. result_ready is registered alongside the state and
   // mirrors state == IDLE; new words are ignored everywhere else, so the
   // holding register only changes on acceptance.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state        <= SEQ_IDLE;
         hold         <= '0;
         idx          <= '0;
         done_tick    <= 1'b0;
         result_ready <= 1'b1;
      end else begin
         done_tick <= 1'b0;
         case (state)
            SEQ_IDLE: begin
               if (result_valid) begin
                  hold         <= result;
                  idx          <= '0;
                  result_ready <= 1'b0;
                  state        <= SEQ_LOAD;
               end
            end
            SEQ_LOAD: begin
               state <= SEQ_SEND;
            end
            SEQ_SEND: begin
               if (stop_done) begin
                  state <= SEQ_NEXT;
               end
            end
            SEQ_NEXT: begin
               if (idx == LAST_IDX) begin
                  done_tick    <= 1'b1;
                  result_ready <= 1'b1;
                  state        <= SEQ_IDLE;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= SEQ_LOAD;
               end
            end
            default: begin
               result_ready <= 1'b1;
               state        <= SEQ_IDLE;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_tx_byte (
      .clk      (clk_100MHz),
      .rst_n    (reset_n),
      .start    (start),
      .data     (cur_byte),
      .tx       (tx),
      .busy     (unused_engine_busy),
      .stop_done(stop_done)
   );

endmodule

// File: tb/tb_uart_float_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_float_tx
// Drives a raw-mode and a hex-mode instance (16 clocks per bit) and decodes
// both tx lines cycle by cycle against a byte scoreboard filled on stimulus.
// ---------------------------------------------------------------------------
module tb_uart_float_tx;

   localparam int BITC = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] result_r, result_h;
   logic        valid_r, valid_h;
   logic        ready_r, tx_r, busy_r, done_r;
   logic        ready_h, tx_h, busy_h, done_h;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_raw[$];
   logic [7:0] exp_hex[$];

   int         cyc[2] = '{-1, -1};
   logic       prev_tx[2] = '{1'b1, 1'b1};
   logic [9:0] frame_bits[2];
   bit         glitch[2];

   uart_float_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .HEX_ASCII(0)) dut_raw (
      .clk_100MHz(clk), .reset_n(reset_n), .result(result_r), .result_valid(valid_r),
      .result_ready(ready_r), .tx(tx_r), .busy(busy_r), .done_tick(done_r));

   uart_float_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .HEX_ASCII(1)) dut_hex (
      .clk_100MHz(clk), .reset_n(reset_n), .result(result_h), .result_valid(valid_h),
      .result_ready(ready_h), .tx(tx_h), .busy(busy_h), .done_tick(done_h));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] asciiOf(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h41 + {4'd0, n} - 8'd10);
   endfunction

   task automatic pushWord(input bit hex, input logic [31:0] w);
      if (hex) begin
         for (int i = 0; i < 8; i++) exp_hex.push_back(asciiOf(w[31-4*i -: 4]));
         exp_hex.push_back(8'h0A);
      end else begin
         for (int i = 0; i < 4; i++) exp_raw.push_back(w[31-8*i -: 8]);
      end
   endtask

   function automatic logic txOf(input bit hex);    return hex ? tx_h : tx_r;       endfunction
   function automatic logic readyOf(input bit hex); return hex ? ready_h : ready_r; endfunction
   function automatic logic busyOf(input bit hex);  return hex ? busy_h : busy_r;   endfunction
   function automatic logic doneOf(input bit hex);  return hex ? done_h : done_r;   endfunction

   // Finished frame on channel ch: framing check, then scoreboard compare
   task automatic frameDone(input int ch);
      logic [7:0] got;
      logic [7:0] want;
      got = frame_bits[ch][8:1];
      checkOutput(ch == 0 ? "raw_framing" : "hex_framing",
                  {29'd0, frame_bits[ch][9], frame_bits[ch][0], glitch[ch]}, 32'h4);
      if (ch == 0) begin
         checkOutput("raw_sb_nonempty", {31'd0, exp_raw.size() != 0}, 32'd1);
         if (exp_raw.size() != 0) begin
            want = exp_raw.pop_front();
            checkOutput("raw_byte", {24'd0, got}, {24'd0, want});
         end
      end else begin
         checkOutput("hex_sb_nonempty", {31'd0, exp_hex.size() != 0}, 32'd1);
         if (exp_hex.size() != 0) begin
            want = exp_hex.pop_front();
            checkOutput("hex_byte", {24'd0, got}, {24'd0, want});
         end
      end
   endtask

   // Line decoder: every bit must be flat for exactly BITC clocks
   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         logic t;
         t = (ch == 0) ? tx_r : tx_h;
         if (!reset_n) begin
            cyc[ch] = -1;
            prev_tx[ch] = 1'b1;
         end else begin
            if (cyc[ch] < 0 && prev_tx[ch] && !t) begin
               cyc[ch] = 0;
               glitch[ch] = 1'b0;
            end
            if (cyc[ch] >= 0) begin
               if (cyc[ch] % BITC == 0) frame_bits[ch][cyc[ch] / BITC] = t;
               else if (t != frame_bits[ch][cyc[ch] / BITC]) glitch[ch] = 1'b1;
               if (cyc[ch] == 10*BITC - 1) begin
                  frameDone(ch);
                  cyc[ch] = -1;
               end else begin
                  cyc[ch]++;
               end
            end
            prev_tx[ch] = t;
         end
      end
   end

   // Present one word, check acceptance latency and optionally sequence length
   task automatic applyStimulus(input bit hex, input logic [31:0] word, input bit waitDone);
      int n;
      int nbytes;
      nbytes = hex ? 9 : 4;
      @(negedge clk);
      if (hex) begin valid_h = 1'b1; result_h = word; end
      else     begin valid_r = 1'b1; result_r = word; end
      pushWord(hex, word);
      n = 0;
      while (!readyOf(hex) && n < 200) begin @(negedge clk); n++; end
      checkOutput("ready_before_accept", {31'd0, readyOf(hex)}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (hex) begin valid_h = 1'b0; result_h = ~word; end
      else     begin valid_r = 1'b0; result_r = ~word; end
      checkOutput("accept_tx_still_high", {31'd0, txOf(hex)}, 32'd1);
      checkOutput("accept_busy", {30'd0, busyOf(hex), readyOf(hex)}, 32'h2);
      @(negedge clk);
      checkOutput("start_bit_latency", {31'd0, txOf(hex)}, 32'd0);
      if (waitDone) begin
         n = 1;
         while (!doneOf(hex) && n < 10*nbytes*BITC + 50) begin @(negedge clk); n++; end
         checkOutput(hex ? "hex_done_cycle" : "raw_done_cycle", n, 10*nbytes*BITC);
         @(negedge clk);
         checkOutput("done_one_cycle", {30'd0, doneOf(hex), readyOf(hex)}, 32'h1);
      end
   endtask

   initial begin
      int n;
      valid_r = 1'b0; valid_h = 1'b0;
      result_r = '0;  result_h = '0;
      reset_n = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("reset_raw", {28'd0, tx_r, ready_r, busy_r, done_r}, 32'hC);
      checkOutput("reset_hex", {28'd0, tx_h, ready_h, busy_h, done_h}, 32'hC);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      applyStimulus(1'b0, 32'h3FC00000, 1'b1);
      applyStimulus(1'b1, 32'hC0080000, 1'b1);

      // Back-to-back with result_valid held high throughout
      @(negedge clk);
      valid_r = 1'b1;
      result_r = 32'h3FC00000;
      pushWord(1'b0, 32'h3FC00000);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_first_accept", {31'd0, busy_r}, 32'd1);
      result_r = 32'hA5A5A5A5;
      repeat (100) @(negedge clk);
      result_r = 32'hC0080000;
      pushWord(1'b0, 32'hC0080000);
      n = 0;
      while (!done_r && n < 50*BITC) begin @(negedge clk); n++; end
      checkOutput("b2b_done_seen", {31'd0, done_r}, 32'd1);
      checkOutput("b2b_ready_with_done", {31'd0, ready_r}, 32'd1);
      @(negedge clk);
      valid_r = 1'b0;
      checkOutput("b2b_second_accept", {30'd0, busy_r, tx_r}, 32'h3);
      @(negedge clk);
      checkOutput("b2b_second_start", {31'd0, tx_r}, 32'd0);
      n = 1;
      while (!done_r && n < 50*BITC) begin @(negedge clk); n++; end
      checkOutput("b2b_second_done_cycle", n, 40*BITC);
      repeat (3) @(negedge clk);

      // Reset during the start bit of byte 2
      applyStimulus(1'b0, 32'h12345678, 1'b0);
      repeat (20*BITC + BITC/2) @(negedge clk);
      checkOutput("pre_reset_tx_low", {31'd0, tx_r}, 32'd0);
      checkOutput("pre_reset_sb_left", exp_raw.size(), 2);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("reset_tx_async", {29'd0, tx_r, ready_r, busy_r}, 32'h6);
      exp_raw.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 32'hDEADBEEF, 1'b1);

      repeat (5) @(negedge clk);
      checkOutput("raw_sb_drained", exp_raw.size(), 0);
      checkOutput("hex_sb_drained", exp_hex.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
